pe_timestep_scheduler: RTL and testbench

- Time-multiplexes one fixed_point_pe across NUM_INPUTS presynaptic channels for one timestep at a time.
- Accepts a spike/polarity vector per timestep through a valid/ready handshake.
- Streams one (spike, polarity, weight) triple per cycle into the PE from an internal weight register file, then returns the PE's output spike activity for that timestep.
- Also owns the PE threshold register, which is loaded through a config port.

---
 rtl/pe_timestep_scheduler_pkg.sv | 14 +
 rtl/pe_timestep_scheduler_spike_index_picker.sv | 22 ++
 rtl/pe_timestep_scheduler.sv | 179 +++++++++++++++++
 tb/tb_pe_timestep_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_timestep_scheduler_pkg.sv
// Shared Q8.8 format constants and FSM state encoding for the PE timestep scheduler.
package pe_timestep_scheduler_pkg;

  localparam int Q_W_WIDTH   = 16;
  localparam int Q_FRAC_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/pe_timestep_scheduler_spike_index_picker.sv
// Combinational lowest-set-bit finder over the remaining spike mask.
module spike_index_picker
  import pe_timestep_scheduler_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int IDX_W      = $clog2(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] mask,
  output logic [IDX_W-1:0]      index,
  output logic                  any
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
      index = mask[i] ? IDX_W'(i) : index;
    end
    any = |mask;
  end

endmodule

// File: rtl/pe_timestep_scheduler.sv
// Time-multiplexes one PE over NUM_INPUTS channels per timestep and reports its spike activity.
module pe_timestep_scheduler
  import pe_timestep_scheduler_pkg::*;
#(
  parameter int NUM_INPUTS = 16,
  parameter int W_WIDTH    = Q_W_WIDTH,
  parameter int PE_LATENCY = 1,
  parameter int SKIP_ZERO  = 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            cfg_we,
  input  logic [$clog2(NUM_INPUTS)-1:0]   cfg_addr,
  input  logic [W_WIDTH-1:0]              cfg_wdata,
  input  logic                            cfg_thr_we,
  output logic                            cfg_ready,
  input  logic                            ts_valid,
  output logic                            ts_ready,
  input  logic [NUM_INPUTS-1:0]           ts_spikes,
  input  logic [NUM_INPUTS-1:0]           ts_polarity,
  output logic                            pe_in_spike,
  output logic                            pe_in_polarity,
  output logic [W_WIDTH-1:0]              pe_in_weight,
  output logic [W_WIDTH-1:0]              pe_threshold,
  input  logic                            pe_out_spike,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            res_spike,
  output logic [$clog2(NUM_INPUTS+1)-1:0] res_count,
  output logic [15:0]                     ts_count
);

  localparam int IDX_W = $clog2(NUM_INPUTS);
  localparam int CNT_W = $clog2(NUM_INPUTS + 1);
  localparam int DRN_W = $clog2(PE_LATENCY + 2);

  sched_state_t          state_r, state_s;
  logic [W_WIDTH-1:0]    weight_r [NUM_INPUTS];
  logic [W_WIDTH-1:0]    thr_r;
  logic [NUM_INPUTS-1:0] spikes_r, pol_r, mask_r, mask_clr_s;
  logic [IDX_W-1:0]      pick_idx_s;
  logic                  pick_any_s;
  logic [DRN_W-1:0]      drain_cnt_r;
  logic                  issued_r, window_r;
  logic [CNT_W-1:0]      res_count_r;
  logic [15:0]           ts_count_r;
  logic                  pe_in_spike_r, pe_in_pol_r;
  logic [W_WIDTH-1:0]    pe_in_weight_r;
  logic                  hs_s, capture_s;

  spike_index_picker #(
    .NUM_INPUTS(NUM_INPUTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .mask (mask_r),
    .index(pick_idx_s),
    .any  (pick_any_s)
  );

  assign hs_s       = (state_r == ST_IDLE) && ts_valid;
  assign mask_clr_s = mask_r & (mask_r - NUM_INPUTS'(1));
  // The first issued input can only produce out_spike from the cycle after it is presented.
  assign capture_s  = window_r && pe_out_spike && ((state_r == ST_STREAM) || (state_r == ST_DRAIN));

  assign ts_ready       = (state_r == ST_IDLE);
  assign cfg_ready      = (state_r == ST_IDLE);
  assign res_valid      = (state_r == ST_DONE);
  assign res_spike      = (res_count_r != '0);
  assign res_count      = res_count_r;
  assign ts_count       = ts_count_r;
  assign pe_in_spike    = pe_in_spike_r;
  assign pe_in_polarity = pe_in_pol_r;
  assign pe_in_weight   = pe_in_weight_r;
  assign pe_threshold   = thr_r;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; DRAIN holds PE_LATENCY+1 cycles so the last out_spike lands in the window.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   state_s = !ts_valid ? ST_IDLE :
                           (((SKIP_ZERO != 0) && (ts_spikes == '0)) ? ST_DRAIN : ST_STREAM);
      ST_STREAM: state_s = (mask_clr_s == '0) ? ST_DRAIN : ST_STREAM;
      ST_DRAIN:  state_s = (drain_cnt_r == DRN_W'(PE_LATENCY)) ? ST_DONE : ST_DRAIN;
      ST_DONE:   state_s = res_ready ? ST_IDLE : ST_DONE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Weight and threshold storage, writable only while idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        weight_r[i] <= '0;
      end
      thr_r <= '0;
    end else if (state_r == ST_IDLE) begin
      if (cfg_we && (int'(cfg_addr) < NUM_INPUTS)) begin
        weight_r[cfg_addr] <= cfg_wdata;
      end
      if (cfg_thr_we) begin
        thr_r <= cfg_wdata;
      end
    end
  end

  // Latched timestep vectors and the mask of channels still to issue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spikes_r <= '0;
      pol_r    <= '0;
      mask_r   <= '0;
    end else if (hs_s) begin
      spikes_r <= ts_spikes;
      pol_r    <= ts_polarity;
      mask_r   <= (SKIP_ZERO != 0) ? ts_spikes : '1;
    end else if (state_r == ST_STREAM) begin
      mask_r <= mask_clr_s;
    end
  end

  // Registered PE input triple; zero whenever nothing is issued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pe_in_spike_r  <= 1'b0;
      pe_in_pol_r    <= 1'b0;
      pe_in_weight_r <= '0;
    end else if ((state_r == ST_STREAM) && pick_any_s) begin
      pe_in_spike_r  <= spikes_r[pick_idx_s];
      pe_in_pol_r    <= pol_r[pick_idx_s];
      pe_in_weight_r <= weight_r[pick_idx_s];
    end else begin
      pe_in_spike_r  <= 1'b0;
      pe_in_pol_r    <= 1'b0;
      pe_in_weight_r <= '0;
    end
  end

  // Drain timer and saturating out_spike accumulator.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drain_cnt_r <= '0;
      issued_r    <= 1'b0;
      window_r    <= 1'b0;
      res_count_r <= '0;
    end else begin
      drain_cnt_r <= (state_r == ST_DRAIN) ? (drain_cnt_r + DRN_W'(1)) : '0;
      if (hs_s) begin
        issued_r    <= 1'b0;
        window_r    <= 1'b0;
        res_count_r <= '0;
      end else begin
        issued_r <= issued_r | (state_r == ST_STREAM);
        window_r <= issued_r;
        if (capture_s && (res_count_r != '1)) begin
          res_count_r <= res_count_r + CNT_W'(1);
        end
      end
    end
  end

  // Completed-timestep counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ts_count_r <= 16'd0;
    end else if ((state_r == ST_DONE) && res_ready) begin
      ts_count_r <= ts_count_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_pe_timestep_scheduler.sv
// Scoreboard bench: driver pushes expectations, monitors compare issued triples and results.
module tb_pe_timestep_scheduler;
  import pe_timestep_scheduler_pkg::*;

  localparam int N   = 16;
  localparam int WW  = Q_W_WIDTH;
  localparam int LAT = 1;
  localparam int SZ  = 1;
  localparam int AW  = $clog2(N);
  localparam int CW  = $clog2(N + 1);

  logic          clk, rstn;
  logic          cfg_we, cfg_thr_we, cfg_ready;
  logic [AW-1:0] cfg_addr;
  logic [WW-1:0] cfg_wdata;
  logic          ts_valid, ts_ready;
  logic [N-1:0]  ts_spikes, ts_polarity;
  logic          pe_in_spike, pe_in_polarity, pe_out_spike;
  logic [WW-1:0] pe_in_weight, pe_threshold;
  logic          res_valid, res_ready, res_spike;
  logic [CW-1:0] res_count;
  logic [15:0]   ts_count;
  logic          pe_q, glitch;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit seen  = 1'b0;

  logic [WW-1:0] m_w [N];
  logic [WW-1:0] m_thr;
  int            m_ts;

  typedef struct { logic sp; int cnt; int hs; int lat; } res_t;
  typedef struct { logic [WW-1:0] w; logic pol; } iss_t;
  res_t res_q[$];
  iss_t iss_q[$];

  pe_timestep_scheduler #(
    .NUM_INPUTS(N), .W_WIDTH(WW), .PE_LATENCY(LAT), .SKIP_ZERO(SZ)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_thr_we(cfg_thr_we), .cfg_ready(cfg_ready),
    .ts_valid(ts_valid), .ts_ready(ts_ready),
    .ts_spikes(ts_spikes), .ts_polarity(ts_polarity),
    .pe_in_spike(pe_in_spike), .pe_in_polarity(pe_in_polarity),
    .pe_in_weight(pe_in_weight), .pe_threshold(pe_threshold),
    .pe_out_spike(pe_out_spike),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_spike(res_spike), .res_count(res_count), .ts_count(ts_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub PE: fires one cycle later for a positive-polarity spike whose weight reaches threshold.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) pe_q <= 1'b0;
    else       pe_q <= pe_in_spike & ~pe_in_polarity & ($signed(pe_in_weight) >= $signed(pe_threshold));
  end
  assign pe_out_spike = pe_q | glitch;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Issue monitor: every presented spike must be the next expected channel.
  always @(negedge clk) begin
    if (rstn && pe_in_spike) begin
      if (iss_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL extra_issue: got weight %0h with no issue expected", pe_in_weight);
      end else begin
        chk("issue_weight", pe_in_weight, iss_q[0].w);
        chk("issue_pol", pe_in_polarity, iss_q[0].pol);
        chk("threshold", pe_threshold, m_thr);
        void'(iss_q.pop_front());
      end
    end
  end

  // Result monitor: latency on first sight, stability and lockout while valid.
  always @(negedge clk) begin
    if (!rstn) begin
      seen = 1'b0;
    end else if (res_valid) begin
      if (res_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_result: got count %0d with none expected", res_count);
      end else begin
        if (!seen) begin
          chk("latency", cyc - res_q[0].hs, res_q[0].lat);
          chk("issues_left", iss_q.size(), 0);
          seen = 1'b1;
        end
        chk("res_spike", res_spike, res_q[0].sp);
        chk("res_count", res_count, res_q[0].cnt);
        chk("ts_ready_busy", ts_ready, 0);
        chk("cfg_ready_busy", cfg_ready, 0);
        if (res_ready) begin
          void'(res_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_ts_ready"}, ts_ready, 1);
    chk({tag, "_cfg_ready"}, cfg_ready, 1);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_spike"}, res_spike, 0);
    chk({tag, "_res_count"}, res_count, 0);
    chk({tag, "_ts_count"}, ts_count, 0);
    chk({tag, "_pe_in_spike"}, pe_in_spike, 0);
    chk({tag, "_pe_in_pol"}, pe_in_polarity, 0);
    chk({tag, "_pe_in_weight"}, pe_in_weight, 0);
    chk({tag, "_threshold"}, pe_threshold, 0);
  endtask

  task automatic cfg(input int addr, input logic [WW-1:0] d, input bit thr);
    cfg_we = !thr; cfg_thr_we = thr; cfg_addr = AW'(addr); cfg_wdata = d;
    @(posedge clk); #1;
    cfg_we = 1'b0; cfg_thr_we = 1'b0;
    if (thr) m_thr = d;
    else if (addr < N) m_w[addr] = d;
  endtask

  task automatic pulse_glitch();
    glitch = 1'b1;
    @(posedge clk); #1;
    glitch = 1'b0;
  endtask

  task automatic send_ts(input logic [N-1:0] sp, input logic [N-1:0] pol,
                         input bit wcfg, input int addr, input logic [WW-1:0] d);
    int cnt, pc;
    cnt = 0; pc = 0;
    @(negedge clk);
    chk("ts_ready_idle", ts_ready, 1);
    chk("cfg_ready_idle", cfg_ready, 1);
    ts_valid = 1'b1; ts_spikes = sp; ts_polarity = pol;
    cfg_we = wcfg; cfg_addr = AW'(addr); cfg_wdata = d;
    if (wcfg) m_w[addr] = d;
    for (int i = 0; i < N; i++) begin
      if (sp[i]) begin
        pc++;
        iss_q.push_back('{w: m_w[i], pol: pol[i]});
        if (!pol[i] && ($signed(m_w[i]) >= $signed(m_thr))) cnt++;
      end
    end
    @(posedge clk); #1;
    ts_valid = 1'b0; cfg_we = 1'b0;
    if (cnt > (1 << CW) - 1) cnt = (1 << CW) - 1;
    res_q.push_back('{sp: (cnt != 0), cnt: cnt, hs: cyc, lat: ((SZ != 0) ? pc : N) + LAT + 1});
  endtask

  task automatic wait_result(input int bp, input bit lock);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = res_valid;
    end
    chk("res_valid_arrives", got, 1);
    if (!got) begin
      res_q.delete(); iss_q.delete();
      return;
    end
    @(posedge clk); #1;
    for (int k = 0; k < bp; k++) begin
      if (lock && k == 1) begin
        cfg_we = 1'b1; cfg_thr_we = 1'b1; cfg_addr = AW'(2); cfg_wdata = 16'h7ABC;
      end else begin
        cfg_we = 1'b0; cfg_thr_we = 1'b0;
      end
      @(posedge clk); #1;
    end
    cfg_we = 1'b0; cfg_thr_we = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    m_ts = (m_ts + 1) & 32'hFFFF;
    @(negedge clk);
    chk("res_valid_drop", res_valid, 0);
    chk("ts_count", ts_count, m_ts);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] sp;
    int nw;
    rstn = 1'b0; cfg_we = 1'b0; cfg_thr_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    ts_valid = 1'b0; ts_spikes = '0; ts_polarity = '0; res_ready = 1'b0; glitch = 1'b0;
    for (int i = 0; i < N; i++) m_w[i] = '0;
    m_thr = '0; m_ts = 0;
    repeat (2) @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;
    rstn = 1'b1;

    // Ramp weights i.0, full vector: 16 consecutive issues, result after 18 cycles.
    for (int i = 0; i < N; i++) cfg(i, WW'(i << Q_FRAC_BITS), 1'b0);
    cfg(0, WW'(30 << Q_FRAC_BITS), 1'b1);
    send_ts(16'hFFFF, 16'h0000, 1'b0, 0, '0);
    wait_result(0, 1'b0);
    // Sparse and empty vectors.
    send_ts(16'h8001, 16'h0000, 1'b0, 0, '0);
    wait_result(1, 1'b0);
    send_ts(16'h0000, 16'h0000, 1'b0, 0, '0);
    wait_result(0, 1'b0);
    // Three channels reach threshold; an idle out_spike pulse must be ignored.
    cfg(0, WW'(13 << Q_FRAC_BITS), 1'b1);
    pulse_glitch();
    send_ts(16'hFFFF, 16'h0000, 1'b0, 0, '0);
    wait_result(2, 1'b0);
    // Long backpressure with config attempts in DONE, then channel 2 read back.
    send_ts(16'h0F0F, 16'h0100, 1'b0, 0, '0);
    wait_result(10, 1'b1);
    send_ts(16'h0004, 16'h0000, 1'b0, 0, '0);
    wait_result(0, 1'b0);
    // Config write coinciding with the handshake.
    send_ts(16'h0021, 16'h0000, 1'b1, 5, 16'h7F00);
    wait_result(0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      nw = $urandom_range(0, 3);
      for (int k = 0; k < nw; k++) cfg($urandom_range(0, N - 1), WW'($urandom), 1'b0);
      if ($urandom_range(0, 3) == 0) cfg(0, WW'($urandom_range(0, 1023)) - WW'(512), 1'b1);
      case ($urandom_range(0, 4))
        0:       sp = '0;
        1:       sp = N'(1) << $urandom_range(0, N - 1);
        default: sp = N'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) pulse_glitch();
      send_ts(sp, N'($urandom), ($urandom_range(0, 1) == 1), $urandom_range(0, N - 1), WW'($urandom));
      wait_result($urandom_range(0, 4), ($urandom_range(0, 1) == 1));
    end

    // Reset while channel 5 is on the PE inputs.
    send_ts(16'hFFFF, N'($urandom), 1'b0, 0, '0);
    repeat (6) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_reset("mid");
    res_q.delete(); iss_q.delete();
    for (int i = 0; i < N; i++) m_w[i] = '0;
    m_thr = '0; m_ts = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("no_res_after_reset", res_valid, 0);
    end
    @(posedge clk); #1;
    send_ts(16'hA5A5, N'($urandom), 1'b0, 0, '0);
    wait_result(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
